// File: rtl/rf_level_stack_if.sv
// Bus between the interrupt controller / decode (master) and rf_level_stack (slave),
// carrying the irq/mret handshake and the level/ra-write outputs routed to rf_stack.
interface rf_level_stack_if #(
  parameter int unsigned PrioNum = 8,
  parameter int unsigned RegW    = 32
);
  localparam int unsigned PrioW = $clog2(PrioNum);

  logic             irqValid;
  logic [PrioW-1:0] irqPrio;
  logic             irqReady;
  logic             mretValid;
  logic [PrioW-1:0] level;
  logic             writeRaEn;
  logic [RegW-1:0]  raData;
  logic [PrioW:0]   depth;
  logic             underflow;

  modport master (
    output irqValid, irqPrio, mretValid,
    input  irqReady, level, writeRaEn, raData, depth, underflow
  );

  modport slave (
    input  irqValid, irqPrio, mretValid,
    output irqReady, level, writeRaEn, raData, depth, underflow
  );
endinterface

// File: rtl/rf_level_stack.sv
// Priority-level tracker for the banked register file: LIFO of preempted levels plus a
// one-cycle ra write on entry. Define RF_LEVEL_TAIL_CHAIN_EN to merge a coincident mret+irq.
module rf_level_stack #(
  parameter int unsigned PrioNum     = 8,
  parameter logic [31:0] ReturnMagic = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            reset,
  rf_level_stack_if.slave bus
);
  localparam int unsigned PrioW  = $clog2(PrioNum);
  localparam int unsigned DepthW = PrioW + 1;
  localparam int unsigned RegW   = 32;

  typedef enum logic {IDLE, ENTRY} state_e;

  state_e            state_q;
  logic [PrioW-1:0]  level_q;
  logic [DepthW-1:0] depth_q;
  logic              write_ra_en_q;
  logic [RegW-1:0]   ra_data_q;
  logic              underflow_q;
  logic [PrioW-1:0]  stack_q [PrioNum];

  logic              idle_c;
  logic              pop_ok_c;
  logic              chain_c;
  logic              accept_c;
  logic [PrioW-1:0]  top_idx_c;
  logic [PrioW-1:0]  top_c;

  // Accept/pop decode; top_c is only meaningful when depth_q is non-zero.
  always_comb begin
    top_idx_c = PrioW'(depth_q - DepthW'(1));
    top_c     = stack_q[top_idx_c];
    idle_c    = (state_q == IDLE);
    pop_ok_c  = idle_c && bus.mretValid && (depth_q != '0);
`ifdef RF_LEVEL_TAIL_CHAIN_EN
    chain_c   = pop_ok_c && bus.irqValid && (bus.irqPrio > top_c);
`else
    chain_c   = 1'b0;
`endif
    accept_c  = (bus.irqValid && (bus.irqPrio > level_q) && idle_c && !bus.mretValid)
                || chain_c;
  end

  // Preempted-level storage; a tail chain keeps the existing top, so no push.
  always_ff @(posedge clk) begin
    if (accept_c && !chain_c) begin
      stack_q[depth_q[PrioW-1:0]] <= level_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      level_q       <= '0;
      depth_q       <= '0;
      write_ra_en_q <= 1'b0;
      ra_data_q     <= '0;
      underflow_q   <= 1'b0;
    end else begin
      write_ra_en_q <= 1'b0;
      ra_data_q     <= '0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            state_q       <= ENTRY;
            level_q       <= bus.irqPrio;
            write_ra_en_q <= 1'b1;
            ra_data_q     <= ReturnMagic;
            if (!chain_c) begin
              depth_q <= depth_q + DepthW'(1);
            end
          end else if (pop_ok_c) begin
            level_q <= top_c;
            depth_q <= depth_q - DepthW'(1);
          end else if (bus.mretValid) begin
            underflow_q <= 1'b1;
          end
        end
        ENTRY: begin
          // An mret here cannot belong to the handler being entered.
          state_q <= IDLE;
          if (bus.mretValid) begin
            underflow_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.irqReady  = accept_c;
  assign bus.level     = level_q;
  assign bus.depth     = depth_q;
  assign bus.writeRaEn = write_ra_en_q;
  assign bus.raData    = ra_data_q;
  assign bus.underflow = underflow_q;

  // Strictly increasing priorities bound the number of stacked levels.
  assert property (@(posedge clk) disable iff (!reset) depth_q <= DepthW'(PrioNum - 1));

endmodule

// File: tb/tb_rf_level_stack.sv
// Self-checking bench for rf_level_stack: vector table with scoreboard queue, plus
// depth sweep, coincident mret/irq, and reset-during-entry sequences.
`timescale 1ns/1ps
module tb_rf_level_stack;
  localparam int unsigned PrioNum = 8;
  localparam int unsigned PrioW   = $clog2(PrioNum);
  localparam logic [31:0] Magic   = 32'hFFFF_FFFF;

  typedef struct {
    logic             rst;
    logic             iv;
    logic [PrioW-1:0] ip;
    logic             mv;
    logic             r;
    logic [PrioW-1:0] l;
    logic [PrioW:0]   d;
    logic             w;
    logic [31:0]      ra;
    logic             u;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t exp_q[$];
  vec_t tbl[$];
  logic [31:0] bank_ra [PrioNum];

  always #5 clk = ~clk;

  rf_level_stack_if #(.PrioNum(PrioNum), .RegW(32)) bus ();

  rf_level_stack #(.PrioNum(PrioNum), .ReturnMagic(Magic)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Minimal stand-in for rf_stack's per-level ra register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PrioNum; i++) bank_ra[i] <= '0;
    end else if (bus.writeRaEn) begin
      bank_ra[bus.level] <= bus.raData;
    end
  end

  function automatic vec_t mk(input int rst, input int iv, input int ip, input int mv,
                              input int r, input int l, input int d, input int w,
                              input logic [31:0] ra, input int u);
    vec_t v;
    v.rst = 1'(rst); v.iv = 1'(iv); v.ip = PrioW'(ip); v.mv = 1'(mv);
    v.r = 1'(r); v.l = PrioW'(l); v.d = (PrioW+1)'(d); v.w = 1'(w); v.ra = ra; v.u = 1'(u);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.irqValid = 1'b0; bus.irqPrio = '0; bus.mretValid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Called at a negedge: drive, check comb ready, then compare registered outputs.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    if (v.rst) do_reset();
    bus.irqValid = v.iv; bus.irqPrio = v.ip; bus.mretValid = v.mv;
    exp_q.push_back(v);
    #1;
    chk($sformatf("%s.irqReady", tag), 32'(bus.irqReady), 32'(v.r));
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("%s.level", tag),     32'(bus.level),     32'(e.l));
      chk($sformatf("%s.depth", tag),     32'(bus.depth),     32'(e.d));
      chk($sformatf("%s.writeRaEn", tag), 32'(bus.writeRaEn), 32'(e.w));
      chk($sformatf("%s.raData", tag),    bus.raData,         e.ra);
      chk($sformatf("%s.underflow", tag), 32'(bus.underflow), 32'(e.u));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    //                 rst iv ip mv  r  l  d  w  ra     u
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 32'h0, 0)); // 0 idle after reset
    tbl.push_back(mk(0, 1, 1, 0,  1, 1, 1, 1, Magic, 0)); // 1 enter level 1
    tbl.push_back(mk(0, 1, 3, 0,  0, 1, 1, 0, 32'h0, 0)); // 2 blocked by ENTRY
    tbl.push_back(mk(0, 1, 3, 0,  1, 3, 2, 1, Magic, 0)); // 3 enter level 3
    tbl.push_back(mk(0, 1, 2, 0,  0, 3, 2, 0, 32'h0, 0)); // 4 ENTRY
    tbl.push_back(mk(0, 1, 2, 0,  0, 3, 2, 0, 32'h0, 0)); // 5 lower prio
    tbl.push_back(mk(0, 1, 3, 0,  0, 3, 2, 0, 32'h0, 0)); // 6 equal prio
    tbl.push_back(mk(0, 0, 0, 1,  0, 1, 1, 0, 32'h0, 0)); // 7 mret -> 1
    tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 32'h0, 0)); // 8 mret -> 0
    tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 32'h0, 1)); // 9 underflow
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 32'h0, 1)); // 10 sticky
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 32'h0, 1)); // 11 prio 0 never
    tbl.push_back(mk(1, 1, 2, 0,  1, 2, 1, 1, Magic, 0)); // 12 reset, enter 2
    tbl.push_back(mk(0, 0, 0, 1,  0, 2, 1, 0, 32'h0, 1)); // 13 mret in ENTRY
    tbl.push_back(mk(0, 0, 0, 0,  0, 2, 1, 0, 32'h0, 1)); // 14 ignored, sticky

    bus.irqValid = 1'b0; bus.irqPrio = '0; bus.mretValid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset.level",     32'(bus.level),     32'h0);
    chk("reset.depth",     32'(bus.depth),     32'h0);
    chk("reset.writeRaEn", 32'(bus.writeRaEn), 32'h0);
    chk("reset.raData",    bus.raData,         32'h0);
    chk("reset.underflow", 32'(bus.underflow), 32'h0);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("v%0d", i));
      if (i == 8) begin
        chk("bank.ra1", bank_ra[1], Magic);
        chk("bank.ra3", bank_ra[3], Magic);
        chk("bank.ra2", bank_ra[2], 32'h0);
      end
    end

    // Fill the stack to its bound and unwind it.
    do_reset();
    for (int p = 1; p < PrioNum; p++) begin
      step(mk(0, 1, p, 0, 1, p, p, 1, Magic, 0), $sformatf("fill%0d", p));
      step(mk(0, 0, 0, 0, 0, p, p, 0, 32'h0, 0), $sformatf("fillidle%0d", p));
    end
    for (int p = PrioNum - 1; p > 0; p--) begin
      step(mk(0, 0, 0, 1, 0, p - 1, p - 1, 0, 32'h0, 0), $sformatf("unwind%0d", p));
    end

    // Coincident mret + irq at level 3 over stack {0,1}.
    step(mk(1, 1, 1, 0, 1, 1, 1, 1, Magic, 0), "co.e1");
    step(mk(0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 0), "co.i1");
    step(mk(0, 1, 3, 0, 1, 3, 2, 1, Magic, 0), "co.e3");
    step(mk(0, 0, 0, 0, 0, 3, 2, 0, 32'h0, 0), "co.i3");
`ifdef RF_LEVEL_TAIL_CHAIN_EN
    step(mk(0, 1, 2, 1, 1, 2, 2, 1, Magic, 0), "co.chain");
    step(mk(0, 1, 2, 0, 0, 2, 2, 0, 32'h0, 0), "co.after");
`else
    step(mk(0, 1, 2, 1, 0, 1, 1, 0, 32'h0, 0), "co.pop");
    step(mk(0, 1, 2, 0, 1, 2, 2, 1, Magic, 0), "co.after");
`endif
    step(mk(0, 0, 0, 0, 0, 2, 2, 0, 32'h0, 0), "co.idle");
    step(mk(0, 1, 1, 1, 0, 1, 1, 0, 32'h0, 0), "co.lowpop");

    // Asynchronous reset while the ra write is in flight.
    step(mk(1, 1, 5, 0, 1, 5, 1, 1, Magic, 0), "rst.enter");
    #2;
    reset = 1'b0;
    #1;
    chk("rst.writeRaEn", 32'(bus.writeRaEn), 32'h0);
    chk("rst.level",     32'(bus.level),     32'h0);
    chk("rst.depth",     32'(bus.depth),     32'h0);
    chk("rst.raData",    bus.raData,         32'h0);
    @(negedge clk);
    bus.irqValid = 1'b0; bus.irqPrio = '0; bus.mretValid = 1'b0;
    reset = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0), "rst.idle");

    bus.irqValid = 1'b0; bus.mretValid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_level_stack.md
# rf_level_stack

Priority-level tracker that drives the `level`, `writeRaEn` and `writeData` inputs of `rf_stack`. It accepts interrupt entries from the interrupt controller and `mret` events from decode, and keeps a LIFO of preempted levels. It presents the current level to the banked register file. On every entry it issues a one-cycle `ra` write of the return magic value into the new bank.

## Interface
- `PrioNum`, default 8: number of priority levels. Level 0 is thread mode. Level width is `PrioT` (`$clog2(PrioNum)` bits).
- `ReturnMagic`, default 32'hFFFF_FFFF: value written to `ra` on entry.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `irqValid` in 1: interrupt request pending.
- `irqPrio` in PrioT: priority of the pending request.
- `irqReady` out 1: entry accepted this cycle; combinational.
- `mretValid` in 1: single-cycle pulse; `mret` retires this cycle.
- `level` out PrioT: current level, routed to `rf_stack.level`.
- `writeRaEn` out 1: routed to `rf_stack.writeRaEn`. Decode forces `writeAddr` to `Ra` and `writeEn` while it is high.
- `raData` out RegT: routed to `rf_stack.writeData` while `writeRaEn` is high.
- `depth` out PrioT+1 bits: number of stacked (preempted) levels.
- `underflow` out 1: sticky error flag.

## Operation
- Storage is a stack of `PrioNum` entries of PrioT, plus the `depth` counter and the `level` register.
- Accept condition: `irqReady = irqValid && (irqPrio > level) && state==IDLE && !mretValid`. Without the macro, an `mret` always blocks entry in the same cycle.
- On accept:
  - push `level` at index `depth`, then `depth += 1`;
  - `level <= irqPrio`;
  - state goes to ENTRY.
- ENTRY state, exactly one cycle:
  - `writeRaEn=1` and `raData=ReturnMagic`;
  - `irqReady=0`;
  - next state is IDLE unconditionally.
- `mret` in IDLE with `depth>0`: `depth -= 1` and `level <= stack[depth-1]`.
- `mret` in IDLE with `depth==0`: ignored; `underflow <= 1`. The flag clears only on reset.
- `mret` during ENTRY: illegal, because the handler has not started. It is ignored and sets `underflow`.
- Overflow is impossible. Strict priority increase bounds `depth` to at most PrioNum-1, and an assertion checks this bound.
- `irqPrio==0` is never accepted.
- FSM states: IDLE and ENTRY.

## Timing
- Reset values:
  - `level=0`, `depth=0`, `writeRaEn=0`, `raData=0`, `underflow=0`;
  - state IDLE, so `irqReady` evaluates from these values;
  - stack contents don't-care.
- Entry latency:
  - `level` changes at the edge that accepts the request;
  - the `ra` write occurs during the following cycle and is committed at the next edge into the bank of the new level;
  - total 2 cycles from accept to `ra` visible in `rf_stack`.
- `mret` latency: `level` restored at the next edge. The bank switch takes effect the same cycle, with no extra cycle.
- Back-to-back entries: the minimum spacing is 2 cycles, because ENTRY blocks acceptance.
- Asynchronous reset mid-ENTRY: the write is aborted and all outputs go to their reset values immediately.

## Configuration
- `RF_LEVEL_TAIL_CHAIN_EN` defined:
  - Applies when `mretValid` and `irqValid` coincide in IDLE, `depth>0`, and `irqPrio > stack[depth-1]`.
  - The pop and push merge (tail chain): `depth` is unchanged, `level <= irqPrio`, `irqReady=1`, and ENTRY follows.
  - If `irqPrio <= stack[depth-1]`, a normal pop occurs.
- Macro undefined: `mret` has precedence and `irqReady=0` in the coincident cycle. The interrupt is re-evaluated next cycle against the restored level.

## Test plan
- Reset check: after reset release, `level=0`, `depth=0`, `writeRaEn=0`, `underflow=0`.
- Nested entry:
  - `irqPrio=1` accepted: `level=1`; the next cycle shows `writeRaEn=1`, `raData=FFFF_FFFF`.
  - `irqPrio=3` accepted: `level=3`, `depth=2`.
  - `irqPrio=2` while at level 3: `irqReady=0`.
- Return: from `level=3`, `depth=2`, two `mret` pulses -> `level=1`, then `level=0`, `depth=0`. A connected `rf_stack` reads `ra=FFFF_FFFF` at level 1.
- Underflow: `mret` at `depth=0` -> `level` stays 0, `underflow=1` and remains 1 until reset.
- Coincident `mret` + `irqPrio=2` at level 3 over stack {0,1}:
  - macro off: `level=1`, `irqReady=0`; accepted next cycle, giving `level=2`, `depth=2`;
  - macro on: immediate `level=2`, `depth=2`, then an ENTRY `ra` write.
- Reset asserted during ENTRY -> `writeRaEn` drops immediately and `level=0`.
